fifo_stage_v: RTL and testbench

Synchronous first-word-fall-through FIFO that buffers a byte stream and drives it into the downstream 8-bit pass-through connect stage. Absorbs rate mismatch between a bursty producer and the consumer. Reports full/empty, occupancy, and sticky overflow/underflow error flags. Single clock domain.

---
 rtl/fifo_stage_v.sv | 110 +++++++++++
 tb/tb_fifo_stage_v.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stage_v.sv
// fifo_stage_v: synchronous first-word-fall-through byte FIFO that feeds
// the downstream 8-bit connect stage and absorbs producer/consumer rate skew.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      write request
//   wr_data    write data, captured when the write is accepted
//   full       FIFO holds DEPTH entries
//   rd_en      pop request
//   rd_data    head entry, 0 while empty
//   empty      FIFO holds no entries
//   count      occupancy, 0..DEPTH
//   overflow   sticky: write requested while full
//   underflow  sticky: read requested while empty
module fifo_stage_v #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic        full_w;
    logic        empty_w;
    logic        wr_acc;
    logic        rd_acc;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // The extra MSB on each pointer separates "same slot, same lap"
    // (empty) from "same slot, one lap ahead" (full).
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_idx == rd_idx)
                  && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Acceptance uses only the registered flags, so a pop in the same
    // cycle never makes room for a write that arrived while full, and
    // a push never feeds a pop that arrived while empty.
    assign wr_acc = wr_en && !full_w;
    assign rd_acc = rd_en && !empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        ovf_d = ovf_q | (wr_en & full_w);
        udf_d = udf_q | (rd_en & empty_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; empty masks whatever is left behind.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data   = empty_w ? '0 : mem_q[rd_idx];
    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = wr_ptr_q - rd_ptr_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_fifo_stage_v.sv
// tb_fifo_stage_v: directed self-checking bench for fifo_stage_v.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_fifo_stage_v;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int n_chk;
    int n_err;

    fifo_stage_v #(
        .DATA_W(8),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_rdata"}, 32'(rd_data), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h55;

        // reset held two cycles with both requests active
        step();
        step();
        idle_state("rst");
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        idle_state("idle");

        // fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_head", 32'(rd_data), 32'h10);
            check("fill_empty", 32'(empty), 0);
        end
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(overflow), 0);

        // rejected 9th write
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_head", 32'(rd_data), 32'h10);

        // drain
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            check("drain_data", 32'(rd_data), 32'(8'h10 + i));
            step();
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_rdata", 32'(rd_data), 0);
        check("drain_count", 32'(count), 0);
        check("drain_udf0", 32'(underflow), 0);
        step();
        rd_en = 1'b0;
        check("udf_set", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);

        // full with both requested
        do_reset();
        check("clr_ovf", 32'(overflow), 0);
        check("clr_udf", 32'(underflow), 0);
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            step();
        end
        check("bf_full", 32'(full), 1);
        rd_en   = 1'b1;
        wr_data = 8'hEE;
        check("bf_head", 32'(rd_data), 32'h20);
        step();
        wr_en = 1'b0;
        check("bf_count", 32'(count), 7);
        check("bf_next", 32'(rd_data), 32'h21);
        check("bf_ovf", 32'(overflow), 1);
        check("bf_full0", 32'(full), 0);
        check("bf_udf", 32'(underflow), 0);
        for (int i = 0; i < 7; i++) begin
            check("bf_drain", 32'(rd_data), 32'(8'h21 + i));
            step();
        end
        rd_en = 1'b0;
        check("bf_dropped", 32'(empty), 1);

        // empty with both requested
        do_reset();
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("be_count", 32'(count), 1);
        check("be_rdata", 32'(rd_data), 32'h3C);
        check("be_udf", 32'(underflow), 1);
        check("be_ovf", 32'(overflow), 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("be_empty", 32'(empty), 1);

        // wrap-around streaming
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        for (int c = 0; c < 40; c++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 8'(c + 3);
            check("wrap_data", 32'(rd_data), 32'(c));
            step();
            check("wrap_count", 32'(count), 3);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_ovf", 32'(overflow), 0);
        check("wrap_udf", 32'(underflow), 0);
        check("wrap_head", 32'(rd_data), 40);

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            step();
        end
        wr_en = 1'b0;
        check("mid_pre", 32'(count), 5);
        do_reset();
        check("mid_empty", 32'(empty), 1);
        check("mid_count", 32'(count), 0);
        check("mid_rdata", 32'(rd_data), 0);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("mid_a5", 32'(rd_data), 32'hA5);
        check("mid_cnt1", 32'(count), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
